status_register_unit: RTL and testbench

//  Holds the architectural NZCV flags (CPSR) and one saved copy (SPSR) for exception entry/return.

---
 rtl/status_register_unit.sv | 73 +++++++
 tb/tb_status_register_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/status_register_unit.sv
// NZCV flag state (CPSR) plus one saved copy (SPSR) for exception entry/return.
// EXE->ID flag hazard is resolved by a same-cycle bypass or a one-cycle stall.
module status_register_unit #(
    parameter bit         FORWARD_EN = 1'b1,
    parameter logic [3:0] AL_COND    = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic [3:0] exe_flags,
    input  logic       msr_we,
    input  logic [3:0] msr_data,
    input  logic       exc_entry,
    input  logic       exc_return,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    output logic       status_n,
    output logic       status_z,
    output logic       status_c,
    output logic       status_v,
    output logic [3:0] cpsr_q,
    output logic [3:0] spsr_q,
    output logic       flag_stall
);

    logic       alu_wr;
    logic       msr_wr;
    logic       ret_take;
    logic [3:0] exe_next;
    logic [3:0] cpsr_next;
    logic [3:0] status;

    assign alu_wr   = exe_valid & exe_s;
    assign msr_wr   = exe_valid & msr_we;
    // Entry wins over a simultaneous return; the EXE instruction still completes.
    assign ret_take = exc_return & ~exc_entry;

    always_comb begin
        exe_next = cpsr_q;
        if (msr_wr)
            exe_next = msr_data;
        else if (alu_wr)
            exe_next = exe_flags;
    end

    assign cpsr_next = ret_take ? spsr_q : exe_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_q <= 4'b0000;
            spsr_q <= 4'b0000;
        end else begin
            cpsr_q <= cpsr_next;
            if (exc_entry)
                spsr_q <= exe_next;
        end
    end

    generate
        if (FORWARD_EN) begin : g_fwd
            assign status     = rst ? 4'b0000 : cpsr_next;
            assign flag_stall = 1'b0;
        end else begin : g_stall
            assign status     = rst ? 4'b0000 : cpsr_q;
            assign flag_stall = ~rst & id_valid & (id_cond != AL_COND)
                              & (alu_wr | msr_wr | exc_return);
        end
    endgenerate

    assign {status_n, status_z, status_c, status_v} = status;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed checks of status_register_unit in both forwarding and stall configurations.
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       exe_valid, exe_s, msr_we, exc_entry, exc_return, id_valid;
    logic [3:0] exe_flags, msr_data, id_cond;

    logic       f_n, f_z, f_c, f_v, f_stall;
    logic [3:0] f_cpsr, f_spsr;
    logic       s_n, s_z, s_c, s_v, s_stall;
    logic [3:0] s_cpsr, s_spsr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_register_unit #(.FORWARD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s), .exe_flags(exe_flags),
        .msr_we(msr_we), .msr_data(msr_data), .exc_entry(exc_entry), .exc_return(exc_return),
        .id_valid(id_valid), .id_cond(id_cond),
        .status_n(f_n), .status_z(f_z), .status_c(f_c), .status_v(f_v),
        .cpsr_q(f_cpsr), .spsr_q(f_spsr), .flag_stall(f_stall)
    );

    status_register_unit #(.FORWARD_EN(1'b0)) u_stl (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s), .exe_flags(exe_flags),
        .msr_we(msr_we), .msr_data(msr_data), .exc_entry(exc_entry), .exc_return(exc_return),
        .id_valid(id_valid), .id_cond(id_cond),
        .status_n(s_n), .status_z(s_z), .status_c(s_c), .status_v(s_v),
        .cpsr_q(s_cpsr), .spsr_q(s_spsr), .flag_stall(s_stall)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks land 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 0; exe_s = 0; exe_flags = 0; msr_we = 0; msr_data = 0;
        exc_entry = 0; exc_return = 0; id_valid = 0; id_cond = 0;
    endtask

    task automatic regs(input string tag, input logic [3:0] cpsr, input logic [3:0] spsr);
        chk({tag, "_fcpsr"}, {4'b0, f_cpsr}, {4'b0, cpsr});
        chk({tag, "_fspsr"}, {4'b0, f_spsr}, {4'b0, spsr});
        chk({tag, "_scpsr"}, {4'b0, s_cpsr}, {4'b0, cpsr});
        chk({tag, "_sspsr"}, {4'b0, s_spsr}, {4'b0, spsr});
    endtask

    initial begin
        idle();
        rst = 1;
        // 1: reset
        step(); step();
        #1;
        chk("rst_fstat", {4'b0, f_n, f_z, f_c, f_v}, 8'h0);
        chk("rst_sstall", {7'b0, s_stall}, 8'h0);
        rst = 0;
        step();
        #1;
        regs("reset", 4'b0000, 4'b0000);
        chk("idle_fstat", {4'b0, f_n, f_z, f_c, f_v}, 8'h0);
        chk("idle_sstat", {4'b0, s_n, s_z, s_c, s_v}, 8'h0);
        chk("idle_stall", {6'b0, f_stall, s_stall}, 8'h0);

        // 2: forwarding of an ALU write
        exe_valid = 1; exe_s = 1; exe_flags = 4'b0100;
        #1;
        chk("fwd_bypass", {4'b0, f_n, f_z, f_c, f_v}, 8'b0100);
        chk("stl_nobypass", {4'b0, s_n, s_z, s_c, s_v}, 8'b0000);
        step(); idle();
        #1;
        regs("alu_wr", 4'b0100, 4'b0000);

        // 3: stall configuration
        exe_valid = 1; exe_s = 1; exe_flags = 4'b1000; id_valid = 1; id_cond = 4'b0100;
        #1;
        chk("stall_on", {6'b0, f_stall, s_stall}, 8'b01);
        chk("stall_stat_old", {4'b0, s_n, s_z, s_c, s_v}, 8'b0100);
        step();
        exe_valid = 0; exe_s = 0;
        #1;
        chk("stall_off", {7'b0, s_stall}, 8'h0);
        chk("stall_stat_new", {7'b0, s_n}, 8'h1);
        exe_valid = 1; exe_s = 1; exe_flags = 4'b1000; id_cond = 4'b1110;
        #1;
        chk("al_nostall", {7'b0, s_stall}, 8'h0);
        step(); idle();

        // 4: MSR priority and invalid EXE
        exe_valid = 1; msr_we = 1; msr_data = 4'b0010;
        step(); idle();
        #1;
        regs("msr", 4'b0010, 4'b0000);
        exe_valid = 1; msr_we = 1; msr_data = 4'b1111; exe_s = 1; exe_flags = 4'b0001;
        step(); idle();
        #1;
        regs("msr_over_alu", 4'b1111, 4'b0000);
        exe_s = 1; exe_flags = 4'b0000; msr_we = 1; msr_data = 4'b0000; id_valid = 1;
        #1;
        chk("inv_nostall", {7'b0, s_stall}, 8'h0);
        step(); idle();
        #1;
        regs("invalid", 4'b1111, 4'b0000);

        // 5: exception entry/return
        exe_valid = 1; msr_we = 1; msr_data = 4'b1010;
        step(); idle();
        exc_entry = 1; exe_valid = 1; exe_s = 1; exe_flags = 4'b0110;
        #1;
        chk("entry_fwd", {4'b0, f_n, f_z, f_c, f_v}, 8'b0110);
        step(); idle();
        #1;
        regs("entry", 4'b0110, 4'b0110);
        exe_valid = 1; msr_we = 1; msr_data = 4'b0001;
        step(); idle();
        #1;
        regs("msr_after_entry", 4'b0001, 4'b0110);
        exc_return = 1; exe_valid = 1; exe_s = 1; exe_flags = 4'b1111; id_valid = 1; id_cond = 4'b0000;
        #1;
        chk("ret_fwd", {4'b0, f_n, f_z, f_c, f_v}, 8'b0110);
        chk("ret_stall", {7'b0, s_stall}, 8'h1);
        step(); idle();
        #1;
        regs("return", 4'b0110, 4'b0110);
        exc_entry = 1; exc_return = 1; exe_valid = 1; exe_s = 1; exe_flags = 4'b1100;
        step(); idle();
        #1;
        regs("entry_ret", 4'b1100, 4'b1100);
        exe_valid = 1; msr_we = 1; msr_data = 4'b0101;
        step(); idle();
        exc_entry = 1; id_valid = 1; id_cond = 4'b0000;
        #1;
        chk("entry_nostall", {7'b0, s_stall}, 8'h0);
        step(); idle();
        #1;
        regs("entry_only", 4'b0101, 4'b0101);

        // 6: reset during a stall
        exe_valid = 1; exe_s = 1; exe_flags = 4'b1001; id_valid = 1; id_cond = 4'b0000;
        #1;
        chk("pre_rst_stall", {7'b0, s_stall}, 8'h1);
        rst = 1;
        #1;
        chk("rst_stall", {7'b0, s_stall}, 8'h0);
        chk("rst_fwd_stat", {4'b0, f_n, f_z, f_c, f_v}, 8'h0);
        chk("rst_stl_stat", {4'b0, s_n, s_z, s_c, s_v}, 8'h0);
        step();
        rst = 0; idle();
        #1;
        regs("post_rst", 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
